// File: rtl/rtc_pkg.sv
// ----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC bus responder: register map addresses, the
// freeze bit position, the bus-decode FSM state type, and the BCD helpers
// used by the time/date/timer stepping logic.
// ----------------------------------------------------------------------------
package rtc_pkg;

   localparam logic [7:0] ADDR_CTRL  = 8'h00;
   localparam logic [7:0] ADDR_SEC   = 8'h21;
   localparam logic [7:0] ADDR_MIN   = 8'h22;
   localparam logic [7:0] ADDR_HOUR  = 8'h23;
   localparam logic [7:0] ADDR_DAY   = 8'h24;
   localparam logic [7:0] ADDR_MON   = 8'h25;
   localparam logic [7:0] ADDR_YEAR  = 8'h26;
   localparam logic [7:0] ADDR_TSEC  = 8'h41;
   localparam logic [7:0] ADDR_TMIN  = 8'h42;
   localparam logic [7:0] ADDR_THOUR = 8'h43;

   localparam int FREEZE_BIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WRITE,
      ST_READ
   } bus_state_e;

   // Number of days in a BCD month. The year is BCD too, so "mod 4 == 0"
   // means: even tens digit with ones in {0,4,8}, or odd tens with {2,6}.
   function automatic logic [7:0] month_len(input logic [7:0] month,
                                            input logic [7:0] year);
      logic leap;
      leap = year[4] ? (year[1:0] == 2'b10) : (year[1:0] == 2'b00);
      case (month)
         8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
         8'h02:                      month_len = leap ? 8'h29 : 8'h28;
         default:                    month_len = 8'h31;
      endcase
   endfunction

   // BCD increment: returns {carry, value}. At or above max it wraps to min.
   // Using >= keeps out-of-range written values from running away.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                          input logic [7:0] max,
                                          input logic [7:0] min);
      if (v >= max)
         bcd_inc = {1'b1, min};
      else if (v[3:0] >= 4'd9)
         bcd_inc = {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {1'b0, v + 8'd1};
   endfunction

   // BCD decrement: returns {borrow, value}. 00 wraps to max with a borrow.
   function automatic logic [8:0] bcd_dec(input logic [7:0] v,
                                          input logic [7:0] max);
      if (v == 8'h00)
         bcd_dec = {1'b1, max};
      else if (v[3:0] == 4'd0)
         bcd_dec = {1'b0, v[7:4] - 4'd1, 4'd9};
      else
         bcd_dec = {1'b0, v - 8'd1};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for one asynchronous bit, plus single-cycle rising and
// falling edge pulses derived from the synchronised value.
// Ports:
//   clk      system clock
//   rst_n_i  asynchronous active-low reset
//   d_i      asynchronous input
//   q_o      synchronised level
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
//   fall_o   one-cycle pulse on a synchronised 1->0 transition
// ----------------------------------------------------------------------------
module sync_edge #(
   // Strobes idle high; resetting to the idle level avoids a false edge.
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// ----------------------------------------------------------------------------
// rtc_bus_responder
// Responder for the multiplexed RTC bus. Decodes address and data phases,
// holds a BCD register file (clock, date, countdown timer) and steps time
// once every TICK_DIV clock cycles unless frozen.
// Ports:
//   clk                      system clock
//   reset                    asynchronous active-low reset
//   cs_n, rd_n, wr_n, ad_n   asynchronous bus strobes (ad_n=0 address phase)
//   bus_in                   pad value of the shared address/data bus
//   bus_out                  read data (0x00 outside a read)
//   bus_oe                   pad output enable
//   timer_done               countdown has reached 00:00:00
// ----------------------------------------------------------------------------
module rtc_bus_responder
   import rtc_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_DIV = CLK_HZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       ad_n,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       timer_done
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   // Strobe synchronisers: index 0 cs_n, 1 rd_n, 2 wr_n, 3 ad_n.
   logic [3:0] strobe_pad, strobe_s, strobe_rise, strobe_fall;
   logic       strobe_unused;
   assign strobe_pad = {ad_n, wr_n, rd_n, cs_n};

   for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      sync_edge #(.RST_VAL(1'b1)) u_sync (
         .clk    (clk),
         .rst_n_i(reset),
         .d_i    (strobe_pad[gi]),
         .q_o    (strobe_s[gi]),
         .rise_o (strobe_rise[gi]),
         .fall_o (strobe_fall[gi])
      );
   end
   assign strobe_unused = ^{strobe_rise[3], strobe_rise[1:0], strobe_fall};

   logic cs_s, rd_s, ad_s, wr_rise, read_cond;
   assign cs_s      = strobe_s[0];
   assign rd_s      = strobe_s[1];
   assign ad_s      = strobe_s[3];
   assign wr_rise   = strobe_rise[2];
   assign read_cond = !cs_s && !rd_s && ad_s;

   logic [7:0] bus_m_q, bus_s_q;

   bus_state_e state_q, state_d;
   logic       addr_wr, data_wr;

   logic [7:0] addr_q, addr_d;
   logic       freeze_q, freeze_d;
   logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0] day_q, day_d, mon_q, mon_d, year_q, year_d;
   logic [7:0] tsec_q, tsec_d, tmin_q, tmin_d, thour_q, thour_d;
   logic       timer_done_q, timer_done_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic       tick_pend_q, tick_pend_d;

   // Bus decode FSM. Address latch and data write are committed on the same
   // edge that leaves IDLE so the write lands 3 cycles after the pad edge.
   always_comb begin
      state_d = state_q;
      addr_wr = 1'b0;
      data_wr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_rise && !cs_s && !ad_s) begin
               state_d = ST_ADDR;
               addr_wr = 1'b1;
            end else if (wr_rise && !cs_s && ad_s) begin
               state_d = ST_WRITE;
               data_wr = 1'b1;
            end else if (read_cond) begin
               state_d = ST_READ;
            end
         end
         ST_ADDR, ST_WRITE: state_d = ST_IDLE;
         ST_READ:           if (!read_cond) state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   // Read mux
   logic [7:0] rd_data;
   always_comb begin
      rd_data = 8'h00;
      case (addr_q)
         ADDR_CTRL:  rd_data[FREEZE_BIT] = freeze_q;
         ADDR_SEC:   rd_data = sec_q;
         ADDR_MIN:   rd_data = min_q;
         ADDR_HOUR:  rd_data = hour_q;
         ADDR_DAY:   rd_data = day_q;
         ADDR_MON:   rd_data = mon_q;
         ADDR_YEAR:  rd_data = year_q;
         ADDR_TSEC:  rd_data = tsec_q;
         ADDR_TMIN:  rd_data = tmin_q;
         ADDR_THOUR: rd_data = thour_q;
         default:    rd_data = 8'h00;
      endcase
   end

   assign bus_oe     = (state_q == ST_READ);
   assign bus_out    = bus_oe ? rd_data : 8'h00;
   assign timer_done = timer_done_q;

   // Step candidates with the carry/borrow chain.
   logic [8:0] sec_n, min_n, hour_n, day_n, mon_n, year_n;
   logic [8:0] tsec_n, tmin_n, thour_n;
   assign sec_n   = bcd_inc(sec_q,  8'h59, 8'h00);
   assign min_n   = bcd_inc(min_q,  8'h59, 8'h00);
   assign hour_n  = bcd_inc(hour_q, 8'h23, 8'h00);
   assign day_n   = bcd_inc(day_q,  month_len(mon_q, year_q), 8'h01);
   assign mon_n   = bcd_inc(mon_q,  8'h12, 8'h01);
   assign year_n  = bcd_inc(year_q, 8'h99, 8'h00);
   assign tsec_n  = bcd_dec(tsec_q,  8'h59);
   assign tmin_n  = bcd_dec(tmin_q,  8'h59);
   assign thour_n = bcd_dec(thour_q, 8'h23);

   logic cy_hour, cy_day, cy_mon, cy_year, timer_zero;
   assign cy_hour    = sec_n[8] & min_n[8];
   assign cy_day     = cy_hour & hour_n[8];
   assign cy_mon     = cy_day & day_n[8];
   assign cy_year    = cy_mon & mon_n[8];
   assign timer_zero = (tsec_q == 8'h00) && (tmin_q == 8'h00) && (thour_q == 8'h00);

   // A pending (deferred) step is honoured even if freeze was just set, so a
   // tick colliding with a write is delayed by one cycle, never lost.
   logic tick_wrap, step_req, step;
   assign tick_wrap = (tick_cnt_q == TICK_LAST);
   assign step_req  = (tick_wrap && !freeze_q) || tick_pend_q;
   assign step      = step_req && !data_wr;

   always_comb begin
      addr_d       = addr_q;
      freeze_d     = freeze_q;
      sec_d        = sec_q;
      min_d        = min_q;
      hour_d       = hour_q;
      day_d        = day_q;
      mon_d        = mon_q;
      year_d       = year_q;
      tsec_d       = tsec_q;
      tmin_d       = tmin_q;
      thour_d      = thour_q;
      timer_done_d = timer_done_q;
      tick_cnt_d   = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      tick_pend_d  = step_req && data_wr;

      if (addr_wr) addr_d = bus_s_q;

      if (data_wr) begin
         case (addr_q)
            ADDR_CTRL:  freeze_d = bus_s_q[FREEZE_BIT];
            ADDR_SEC:   sec_d  = bus_s_q;
            ADDR_MIN:   min_d  = bus_s_q;
            ADDR_HOUR:  hour_d = bus_s_q;
            ADDR_DAY:   day_d  = bus_s_q;
            ADDR_MON:   mon_d  = bus_s_q;
            ADDR_YEAR:  year_d = bus_s_q;
            ADDR_TSEC:  begin tsec_d  = bus_s_q; timer_done_d = 1'b0; end
            ADDR_TMIN:  begin tmin_d  = bus_s_q; timer_done_d = 1'b0; end
            ADDR_THOUR: begin thour_d = bus_s_q; timer_done_d = 1'b0; end
            default:    ;
         endcase
      end

      if (step) begin
         sec_d = sec_n[7:0];
         if (sec_n[8]) min_d  = min_n[7:0];
         if (cy_hour)  hour_d = hour_n[7:0];
         if (cy_day)   day_d  = day_n[7:0];
         if (cy_mon)   mon_d  = mon_n[7:0];
         if (cy_year)  year_d = year_n[7:0];
         if (!timer_zero) begin
            tsec_d = tsec_n[7:0];
            if (tsec_n[8])              tmin_d  = tmin_n[7:0];
            if (tsec_n[8] && tmin_n[8]) thour_d = thour_n[7:0];
            // Only 00:00:01 can decrement to zero.
            if (tsec_q == 8'h01 && tmin_q == 8'h00 && thour_q == 8'h00)
               timer_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_m_q      <= 8'h00;
         bus_s_q      <= 8'h00;
         state_q      <= ST_IDLE;
         addr_q       <= 8'h00;
         freeze_q     <= 1'b0;
         sec_q        <= 8'h00;
         min_q        <= 8'h00;
         hour_q       <= 8'h00;
         day_q        <= 8'h01;
         mon_q        <= 8'h01;
         year_q       <= 8'h00;
         tsec_q       <= 8'h00;
         tmin_q       <= 8'h00;
         thour_q      <= 8'h00;
         timer_done_q <= 1'b0;
         tick_cnt_q   <= '0;
         tick_pend_q  <= 1'b0;
      end else begin
         bus_m_q      <= bus_in;
         bus_s_q      <= bus_m_q;
         state_q      <= state_d;
         addr_q       <= addr_d;
         freeze_q     <= freeze_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         day_q        <= day_d;
         mon_q        <= mon_d;
         year_q       <= year_d;
         tsec_q       <= tsec_d;
         tmin_q       <= tmin_d;
         thour_q      <= thour_d;
         timer_done_q <= timer_done_d;
         tick_cnt_q   <= tick_cnt_d;
         tick_pend_q  <= tick_pend_d;
      end
   end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_rtc_bus_responder
// Directed bench for rtc_bus_responder with TICK_DIV=8. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_rtc_bus_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs_n, rd_n, wr_n, ad_n;
   logic [7:0] bus_in, bus_out;
   logic       bus_oe, timer_done;

   int checks = 0;
   int errors = 0;

   rtc_bus_responder #(.TICK_DIV(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .cs_n      (cs_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .ad_n      (ad_n),
      .bus_in    (bus_in),
      .bus_out   (bus_out),
      .bus_oe    (bus_oe),
      .timer_done(timer_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%02h expected=%02h", tag, got, exp);
      end else begin
         $display("ok   %s got=%02h", tag, got);
      end
   endtask

   // One bus write strobe, exactly 8 cycles long; wr_n rises 3 cycles in.
   task automatic bus_write(input logic ad, input logic [7:0] val);
      cs_n = 1'b0; ad_n = ad; bus_in = val; wr_n = 1'b0;
      repeat (3) @(negedge clk);
      wr_n = 1'b1;
      repeat (3) @(negedge clk);
      cs_n = 1'b1; ad_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      bus_write(1'b0, a);
      bus_write(1'b1, d);
   endtask

   task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] d;
      bus_write(1'b0, a);
      cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0;
      repeat (5) @(negedge clk);
      check({tag, "_oe"}, {7'd0, bus_oe}, 8'h01);
      d = bus_out;
      rd_n = 1'b1; cs_n = 1'b1;
      repeat (4) @(negedge clk);
      check(tag, d, exp);
      check({tag, "_oe_off"}, {7'd0, bus_oe}, 8'h00);
   endtask

   // Unfreeze, then refreeze exactly 8*k cycles later: exactly k ticks apply.
   task automatic run_ticks(input int k);
      bus_write(1'b0, 8'h00);
      bus_write(1'b1, 8'h00);
      repeat (8 * k - 8) @(negedge clk);
      bus_write(1'b1, 8'h10);
   endtask

   task automatic set_eod();
      reg_write(8'h21, 8'h59);
      reg_write(8'h22, 8'h59);
      reg_write(8'h23, 8'h23);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; ad_n = 1'b1; bus_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_oe", {7'd0, bus_oe}, 8'h00);
      check("rst_out", bus_out, 8'h00);
      check("rst_done", {7'd0, timer_done}, 8'h00);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Freeze, then reset values of the date, timer and an unmapped address.
      reg_write(8'h00, 8'h10);
      read_check("ctrl", 8'h00, 8'h10);
      read_check("rst_day", 8'h24, 8'h01);
      read_check("rst_mon", 8'h25, 8'h01);
      read_check("rst_year", 8'h26, 8'h00);
      read_check("rst_tsec", 8'h41, 8'h00);
      read_check("unmapped", 8'h30, 8'h00);
      reg_write(8'h30, 8'h77);
      read_check("unmapped_wr", 8'h30, 8'h00);

      // Full rollover from 23:59:59 31/12/99.
      set_eod();
      reg_write(8'h24, 8'h31);
      reg_write(8'h25, 8'h12);
      reg_write(8'h26, 8'h99);
      run_ticks(1);
      read_check("roll_sec", 8'h21, 8'h00);
      read_check("roll_min", 8'h22, 8'h00);
      read_check("roll_hour", 8'h23, 8'h00);
      read_check("roll_day", 8'h24, 8'h01);
      read_check("roll_mon", 8'h25, 8'h01);
      read_check("roll_year", 8'h26, 8'h00);

      // February in a leap year (24) and a common year (23).
      set_eod();
      reg_write(8'h26, 8'h24);
      reg_write(8'h25, 8'h02);
      reg_write(8'h24, 8'h28);
      run_ticks(1);
      read_check("leap_d29", 8'h24, 8'h29);
      read_check("leap_m02", 8'h25, 8'h02);
      set_eod();
      run_ticks(1);
      read_check("leap_d01", 8'h24, 8'h01);
      read_check("leap_m03", 8'h25, 8'h03);
      set_eod();
      reg_write(8'h26, 8'h23);
      reg_write(8'h25, 8'h02);
      reg_write(8'h24, 8'h28);
      run_ticks(1);
      read_check("nonleap_d01", 8'h24, 8'h01);
      read_check("nonleap_m03", 8'h25, 8'h03);

      // Countdown timer to zero, hold, then clear by write.
      reg_write(8'h41, 8'h02);
      reg_write(8'h42, 8'h00);
      reg_write(8'h43, 8'h00);
      check("tmr_notdone", {7'd0, timer_done}, 8'h00);
      run_ticks(2);
      check("tmr_done", {7'd0, timer_done}, 8'h01);
      read_check("tmr_sec0", 8'h41, 8'h00);
      run_ticks(3);
      read_check("tmr_hold_s", 8'h41, 8'h00);
      read_check("tmr_hold_m", 8'h42, 8'h00);
      read_check("tmr_hold_h", 8'h43, 8'h00);
      check("tmr_done_hold", {7'd0, timer_done}, 8'h01);
      reg_write(8'h41, 8'h05);
      check("tmr_clear", {7'd0, timer_done}, 8'h00);
      // Borrow: 00:01:00 -> 00:00:59
      reg_write(8'h41, 8'h00);
      reg_write(8'h42, 8'h01);
      run_ticks(1);
      read_check("tmr_borrow_s", 8'h41, 8'h59);
      read_check("tmr_borrow_m", 8'h42, 8'h00);

      // Freeze drops ticks; unfreezing resumes.
      reg_write(8'h21, 8'h10);
      repeat (160) @(negedge clk);
      read_check("frozen_sec", 8'h21, 8'h10);
      run_ticks(1);
      read_check("resume_sec", 8'h21, 8'h11);

      // Write colliding with a tick. Timer 00:00:01 expiring marks the tick
      // phase (step edge S); the seconds write then commits at S+16, a wrap
      // edge, so it is stepped at S+17. Steps also at S+24 and, deferred by
      // the refreeze write committing at S+32, at S+33: 0x30 + 3 = 0x33.
      reg_write(8'h41, 8'h01);
      reg_write(8'h42, 8'h00);
      reg_write(8'h43, 8'h00);
      bus_write(1'b0, 8'h00);
      bus_write(1'b1, 8'h00);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (timer_done) break;
      end
      check("phase_found", {7'd0, timer_done}, 8'h01);
      bus_write(1'b0, 8'h21);
      repeat (2) @(negedge clk);
      bus_write(1'b1, 8'h30);
      bus_write(1'b0, 8'h00);
      bus_write(1'b1, 8'h10);
      read_check("collide_sec", 8'h21, 8'h33);

      // Reset in the middle of a read window.
      bus_write(1'b0, 8'h25);
      cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0;
      repeat (5) @(negedge clk);
      check("midrd_oe", {7'd0, bus_oe}, 8'h01);
      check("midrd_out", bus_out, 8'h03);
      #2 reset = 1'b0;
      #1;
      check("async_oe", {7'd0, bus_oe}, 8'h00);
      check("async_out", bus_out, 8'h00);
      cs_n = 1'b1; rd_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      read_check("rerst_mon", 8'h25, 8'h01);
      read_check("rerst_ctrl", 8'h00, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

On-chip responder for the multiplexed RTC bus (chip-select, read, write and address/data strobes, all active-low, plus an 8-bit shared address/data bus) driven by the user-control mux. It decodes address and data phases, holds a BCD register file for clock, date and countdown timer, and advances time once per second. It is a drop-in replacement for the external RTC chip, and also serves as the bench's bus model.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: system clock frequency, used for the 1 Hz tick.
- `TICK_DIV`, default `CLK_HZ`: cycles per tick; benches override it to 8.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cs_n`, `rd_n`, `wr_n`, `ad_n`  in  1 each  bus strobes, asynchronous to `clk`. `ad_n`=0 selects the address phase; `ad_n`=1 selects the data phase.
- `bus_in`  in  8  bus value sampled from the pad.
- `bus_out`  out  8  read data.
- `bus_oe`  out  1  pad output enable.
- `timer_done`  out  1  level signal: countdown reached 00:00:00.

## Operation
- Input synchronisation: the four strobes and `bus_in` pass through 2-flop synchronisers. Edge detection is done on the synchronised strobes.
- Address phase: a rising edge of synced `wr_n` with `cs_n`=0 and `ad_n`=0 latches `bus_in` into `addr`.
- Data write: a rising edge of synced `wr_n` with `cs_n`=0 and `ad_n`=1 writes `bus_in` to `reg[addr]`.
  - Writes to unmapped addresses are discarded.
  - No BCD validation is performed.
- Data read: while synced `cs_n`=0, `rd_n`=0 and `ad_n`=1, `bus_oe`=1 and `bus_out`=`reg[addr]`. Unmapped addresses read 0x00.
- Register map (BCD):
  - 0x00 control: bit4 = freeze; other bits read 0.
  - 0x21 seconds, 0x22 minutes, 0x23 hours (00-23), 0x24 day, 0x25 month, 0x26 year (00-99).
  - 0x41, 0x42, 0x43 timer seconds, minutes, hours.
- Tick: a counter counts 0 to `TICK_DIV`-1. When it wraps, and freeze=0, one time step is applied.
  - Clock: seconds 59→00 carries into minutes; minutes 59→00 carries into hours; hours 23→00 carries into day.
  - Day wraps to 01 after the month length. February has 29 days when the year value mod 4 = 0, otherwise 28. Day wrap carries into month; month 12→01 carries into year; year 99→00.
  - Timer, when nonzero: decrements with BCD borrow (sec 00→59 borrows from min, min 00→59 borrows from hour). On reaching 00:00:00 it sets `timer_done`.
  - `timer_done` clears on any data write to 0x41-0x43.
- FSM for bus decode: IDLE → ADDR (address edge, back to IDLE after 1 cycle) / WRITE (data write edge, 1 cycle) / READ (held while the read condition holds). Any strobe combination other than these stays in IDLE.
- Reset values: `addr`=0x00; all registers 0x00 except day=0x01 and month=0x01; tick counter 0; `bus_oe`=0; `bus_out`=0x00; `timer_done`=0.

## Timing
- Write commit: `reg` is updated on the 3rd `clk` rising edge after the pad `wr_n` rising edge (2 sync cycles + 1 edge detect cycle).
- Read: `bus_oe` and `bus_out` are valid 3 cycles after pad `rd_n` falls, and drop 3 cycles after `rd_n` or `cs_n` rises. The controller must hold `rd_n` low for ≥5 cycles and keep `bus_in` stable for ≥3 cycles before the `wr_n` rising edge.
- Write and tick in the same cycle: the write is applied and the tick is deferred exactly one cycle, so no tick is lost and the written value then advances.
- Freeze=1: ticks are dropped, not queued. The tick counter keeps running.
- Reset asserted mid-transaction: immediate return to the reset values; `bus_oe` goes to 0 asynchronously.
- Timer at 00:00:00 with `timer_done`=1: the timer holds; no underflow.

## Structure
- Package `rtc_pkg`: register address constants, the freeze bit index, the BCD month-length function, and the FSM state enum.
- Sub-module `sync_edge`: 2-flop synchroniser with rising and falling edge pulse outputs. Instantiate it once per strobe.
- BCD increment and decrement with carry/borrow are implemented as functions in `rtc_pkg`.

## Test plan
- Reset release → reading 0x24 returns 0x01, reading 0x21 returns 0x00, `bus_oe`=0 outside the read window.
- Address 0x21, write 0x59; address 0x22, write 0x59; address 0x23, write 0x23; date set to 31/12/99; one tick (`TICK_DIV`=8) → time 00:00:00, day 01, month 01, year 00.
- Year 0x24, month 0x02, day 0x28, one tick → day 0x29; next tick → day 0x01, month 0x03. With year 0x23 and the same start date, the first tick gives day 0x01, month 0x03.
- Timer set to 00:00:02, two ticks → `timer_done`=1 and timer 00:00:00; further ticks hold. Writing 0x05 to 0x41 → `timer_done`=0.
- Control written 0x10, 20 ticks → seconds unchanged. Control written 0x00 → seconds advance again.
- Data write to 0x21 landing in a tick cycle → register equals the written value +1 one cycle later. Read of 0x30 → 0x00.
